// File: rtl/isr_prefetch_queue.sv
// isr_prefetch_queue
//   Instruction register (ISR) with a prefetch FIFO behind it. Fetched words
//   from m_bus are buffered in the FIFO. ISR holds the word being decoded, and
//   ISR_next exposes the following word, so two-word instructions decode
//   without a refetch. flush empties everything on branch or interrupt entry.
// Ports
//   CLK        clock, all state updates on rising edge
//   CLR        synchronous active-high reset
//   m_bus      fetched instruction word
//   ld_valid   m_bus carries a fetched word this cycle
//   ld_ready   queue accepts a word this cycle (FIFO not full)
//   adv        decoder retires the current ISR word
//   flush      discard all queued words
//   ISR        current instruction word (registered)
//   isr_valid  ISR holds a valid word
//   ISR_next   FIFO head word, 0 when the FIFO is empty
//   next_valid FIFO non-empty
//   count      isr_valid + FIFO entries, 0..DEPTH+1
//   ovf        sticky flag: a word was offered while ld_ready was low
module isr_prefetch_queue #(
   parameter int unsigned IW    = 16,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 2)
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic [IW-1:0] m_bus,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic          adv,
   input  logic          flush,
   output logic [IW-1:0] ISR,
   output logic          isr_valid,
   output logic [IW-1:0] ISR_next,
   output logic          next_valid,
   output logic [CW-1:0] count,
   output logic          ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [IW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] fifo_cnt;
   logic          fifo_empty;
   logic          fifo_full;
   logic          load_slot;
   logic          pop;
   logic          bypass;
   logic          push;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // index with differing wrap bit means full.
   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
   assign fifo_cnt   = wr_ptr - rd_ptr;

   assign ld_ready   = !fifo_full;
   assign next_valid = !fifo_empty;
   assign ISR_next   = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign count      = CW'(fifo_cnt) + CW'(isr_valid);

   // ISR can take a new word when empty, or when the decoder retires it.
   // An empty FIFO lets the incoming word bypass straight into ISR.
   assign load_slot = !isr_valid || adv;
   assign pop       = load_slot && !fifo_empty;
   assign bypass    = load_slot && fifo_empty && ld_valid;
   assign push      = ld_valid && ld_ready && !bypass;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         ISR       <= '0;
         isr_valid <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         ovf       <= 1'b0;
      end else if (flush) begin
         ISR       <= '0;
         isr_valid <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         if (ld_valid && !ld_ready) begin
            ovf <= 1'b1;
         end
         if (load_slot) begin
            if (pop) begin
               ISR       <= mem[rd_ptr[AW-1:0]];
               isr_valid <= 1'b1;
            end else if (ld_valid) begin
               ISR       <= m_bus;
               isr_valid <= 1'b1;
            end else begin
               isr_valid <= 1'b0;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge CLK) begin
      if (!CLR && !flush && push) begin
         mem[wr_ptr[AW-1:0]] <= m_bus;
      end
   end

endmodule

// File: tb/tb_isr_prefetch_queue.sv
// tb_isr_prefetch_queue
//   Directed bench for isr_prefetch_queue at DEPTH=4, followed by a seeded
//   pseudo-random push/adv/flush run checked against a queue model.
module tb_isr_prefetch_queue;

   localparam int unsigned IW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 2);

   logic          CLK = 1'b0;
   logic          CLR;
   logic [IW-1:0] m_bus;
   logic          ld_valid;
   logic          ld_ready;
   logic          adv;
   logic          flush;
   logic [IW-1:0] ISR;
   logic          isr_valid;
   logic [IW-1:0] ISR_next;
   logic          next_valid;
   logic [CW-1:0] count;
   logic          ovf;

   int tests = 0;
   int fails = 0;

   isr_prefetch_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .m_bus     (m_bus),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .adv       (adv),
      .flush     (flush),
      .ISR       (ISR),
      .isr_valid (isr_valid),
      .ISR_next  (ISR_next),
      .next_valid(next_valid),
      .count     (count),
      .ovf       (ovf)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic lv, input logic [IW-1:0] d, input logic a, input logic f);
      ld_valid = lv;
      m_bus    = d;
      adv      = a;
      flush    = f;
      @(posedge CLK);
      #1;
      ld_valid = 1'b0;
      adv      = 1'b0;
      flush    = 1'b0;
      m_bus    = '0;
   endtask

   task automatic do_reset();
      CLR = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b0);
      CLR = 1'b0;
   endtask

   // Reference model state for the random phase
   logic [IW-1:0] m_isr;
   logic          m_v;
   logic          m_ovf;
   logic [IW-1:0] m_q[$];

   initial begin
      CLR = 1'b0; m_bus = '0; ld_valid = 1'b0; adv = 1'b0; flush = 1'b0;
      #2;
      do_reset();
      do_reset();
      chk("rst_isr_valid", 64'(isr_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_isr", 64'(ISR), 64'd0);
      chk("rst_ld_ready", 64'(ld_ready), 64'd1);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_next_valid", 64'(next_valid), 64'd0);

      // T2: single word into empty queue bypasses to ISR in one cycle
      cyc(1'b1, 16'h1234, 1'b0, 1'b0);
      chk("t2_isr", 64'(ISR), 64'h1234);
      chk("t2_isr_valid", 64'(isr_valid), 64'd1);
      chk("t2_count", 64'(count), 64'd1);
      chk("t2_next_valid", 64'(next_valid), 64'd0);
      chk("t2_isr_next", 64'(ISR_next), 64'd0);

      // T1: three words queued behind ISR, then CLR
      cyc(1'b1, 16'hB001, 1'b0, 1'b0);
      cyc(1'b1, 16'hB002, 1'b0, 1'b0);
      cyc(1'b1, 16'hB003, 1'b0, 1'b0);
      chk("t1_count_pre", 64'(count), 64'd4);
      chk("t1_isr_next_pre", 64'(ISR_next), 64'hB001);
      do_reset();
      chk("t1_isr_valid", 64'(isr_valid), 64'd0);
      chk("t1_count", 64'(count), 64'd0);
      chk("t1_isr", 64'(ISR), 64'd0);
      chk("t1_ld_ready", 64'(ld_ready), 64'd1);
      chk("t1_ovf", 64'(ovf), 64'd0);

      // T3: fill to DEPTH+1, overflow, then drain in order
      for (int i = 1; i <= 5; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
      chk("t3_count_full", 64'(count), 64'd5);
      chk("t3_ld_ready_full", 64'(ld_ready), 64'd0);
      chk("t3_ovf_before", 64'(ovf), 64'd0);
      chk("t3_isr_head", 64'(ISR), 64'hA001);
      chk("t3_isr_next", 64'(ISR_next), 64'hA002);
      cyc(1'b1, 16'hA006, 1'b0, 1'b0);
      chk("t3_ovf", 64'(ovf), 64'd1);
      chk("t3_count_after_ovf", 64'(count), 64'd5);
      for (int i = 2; i <= 5; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("t3_drain_isr", 64'(ISR), 64'(16'hA000 + 16'(i)));
         chk("t3_drain_count", 64'(count), 64'(6 - i));
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t3_empty_valid", 64'(isr_valid), 64'd0);
      chk("t3_empty_count", 64'(count), 64'd0);
      chk("t3_isr_hold", 64'(ISR), 64'hA005);
      chk("t3_ovf_sticky", 64'(ovf), 64'd1);
      do_reset();
      chk("t3_ovf_cleared", 64'(ovf), 64'd0);

      // T4: full queue with adv & ld_valid: word still dropped
      for (int i = 1; i <= 5; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
      cyc(1'b1, 16'hC006, 1'b1, 1'b0);
      chk("t4_full_isr", 64'(ISR), 64'hC002);
      chk("t4_full_count", 64'(count), 64'd4);
      chk("t4_full_ovf", 64'(ovf), 64'd1);
      chk("t4_ld_ready", 64'(ld_ready), 64'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t4_count3", 64'(count), 64'd3);
      cyc(1'b1, 16'hD001, 1'b1, 1'b0);
      chk("t4_pp_count", 64'(count), 64'd3);
      chk("t4_pp_isr", 64'(ISR), 64'hC004);
      chk("t4_pp_next", 64'(ISR_next), 64'hC005);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t4_ord1_isr", 64'(ISR), 64'hC005);
      chk("t4_ord1_next", 64'(ISR_next), 64'hD001);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t4_ord2_isr", 64'(ISR), 64'hD001);
      chk("t4_ord2_count", 64'(count), 64'd1);

      // T5: flush with same-cycle ld_valid and adv
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, 16'h8100, 1'b0, 1'b0);
      cyc(1'b1, 16'h00FF, 1'b0, 1'b0);
      chk("t5_isr_pre", 64'(ISR), 64'h8100);
      chk("t5_next_pre", 64'(ISR_next), 64'h00FF);
      cyc(1'b1, 16'h5555, 1'b1, 1'b1);
      chk("t5_isr_valid", 64'(isr_valid), 64'd0);
      chk("t5_next_valid", 64'(next_valid), 64'd0);
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_isr", 64'(ISR), 64'd0);
      chk("t5_ld_ready", 64'(ld_ready), 64'd1);
      chk("t5_ovf_kept", 64'(ovf), 64'd1);

      // Seeded random phase against a queue model
      do_reset();
      m_isr = '0; m_v = 1'b0; m_ovf = 1'b0; m_q.delete();
      void'($urandom(32'h1BAD));
      for (int n = 0; n < 400; n++) begin
         logic          lv, a, f, rdy, slot, byp;
         logic [IW-1:0] d;
         logic [63:0]   exp_v, obs_v;
         lv = ($urandom_range(9) < 6);
         a  = ($urandom_range(1) == 1);
         f  = ($urandom_range(24) == 0);
         d  = IW'($urandom);
         if (f) begin
            m_isr = '0; m_v = 1'b0; m_q.delete();
         end else begin
            rdy  = (m_q.size() < DEPTH);
            byp  = 1'b0;
            if (lv && !rdy) m_ovf = 1'b1;
            slot = !m_v || a;
            if (slot) begin
               if (m_q.size() > 0) begin
                  m_isr = m_q.pop_front(); m_v = 1'b1;
               end else if (lv) begin
                  m_isr = d; m_v = 1'b1; byp = 1'b1;
               end else begin
                  m_v = 1'b0;
               end
            end
            if (lv && rdy && !byp) m_q.push_back(d);
         end
         cyc(lv, d, a, f);
         exp_v = {m_isr, m_v, (m_q.size() > 0) ? m_q[0] : 16'h0, (m_q.size() > 0),
                  CW'(m_q.size() + int'(m_v)), (m_q.size() < DEPTH), m_ovf};
         obs_v = {ISR, isr_valid, ISR_next, next_valid, count, ld_ready, ovf};
         chk("rand_state", obs_v, exp_v);
         chk("rand_count_range", 64'(int'(count) <= DEPTH + 1), 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
